mem_initiator: RTL and testbench

CPU-side bus initiator for the 32 KiB × 8 SRAM block. It accepts one load or store request at a time from the datapath over a valid/ready handshake and drives the RAM's address, write-enable and data-in lines with registered, glitch-free timing. It samples read data after a fixed settle interval and returns a response over a second valid/ready handshake. It sits between the CPU memory stage and the RAM block; the RAM's write pulse is derived from a positive edge of `mem_wr`.

---
 rtl/mem_initiator.sv | 182 ++++++++++++++++++
 tb/tb_mem_initiator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// mem_initiator: CPU-side bus initiator for a 32 KiB x 8 asynchronous SRAM.
// Accepts one load/store at a time over a valid/ready handshake and drives
// the RAM address, write request and write data from flops, so the RAM sees
// glitch-free lines. Returns load data (or the echoed store data) over a
// second valid/ready handshake.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_addr        byte address (full range legal, used as given)
//   req_wdata       store data
//   rsp_valid/ready response handshake
//   rsp_rdata       load data, or store data echoed back
//   mem_address     RAM address, changes only on request accept
//   mem_wr          RAM write request, high only during WRITE
//   mem_din         RAM write data, changes only on request accept
//   mem_dout        RAM read data (combinational from mem_address)

module mem_initiator #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 3,
    parameter int RD_WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_MAX = (WR_CYCLES > RD_WAIT) ? WR_CYCLES : RD_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_WR  = CNT_W'(WR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RD  = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_READ,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [ADDR_W-1:0]   r_mem_address;
    logic [ADDR_W-1:0]   w_mem_address_nxt;

    logic [DATA_W-1:0]   r_mem_din;
    logic [DATA_W-1:0]   w_mem_din_nxt;

    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;

    logic                r_mem_wr;
    logic                w_mem_wr_nxt;

    logic                w_accept;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers. mem_wr is a flop whose next value is exactly
    // "next state is WRITE", so it is high for precisely the WRITE cycles
    // and drops asynchronously with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_mem_address <= '0;
            r_mem_din     <= '0;
            r_rsp_rdata   <= '0;
            r_mem_wr      <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_din     <= w_mem_din_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_mem_wr      <= w_mem_wr_nxt;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_mem_address_nxt = r_mem_address;
        w_mem_din_nxt     = r_mem_din;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_mem_wr_nxt      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mem_address_nxt = req_addr;
                    if (req_we) begin
                        w_mem_din_nxt   = req_wdata;
                        w_rsp_rdata_nxt = req_wdata;
                        w_state_nxt     = S_SETUP;
                    end else begin
                        w_cnt_nxt   = CNT_RD;
                        w_state_nxt = S_READ;
                    end
                end
            end

            // One quiet cycle so address/data settle before the write edge.
            S_SETUP: begin
                w_cnt_nxt    = CNT_WR;
                w_mem_wr_nxt = 1'b1;
                w_state_nxt  = S_WRITE;
            end

            S_WRITE: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_mem_wr_nxt = 1'b1;
                end
            end

            // Address/data held one more cycle after mem_wr falls.
            S_HOLD: begin
                w_state_nxt = S_RESP;
            end

            S_READ: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt <= CNT_ONE) begin
                    w_rsp_rdata_nxt = mem_dout;
                    w_state_nxt     = S_RESP;
                end
            end

            // Returning to IDLE (not accepting here) keeps a dead cycle
            // between response consumption and the next accept.
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign mem_address = r_mem_address;
    assign mem_din     = r_mem_din;
    assign mem_wr      = r_mem_wr;

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: vector table, hand sequences and random traffic
// against a behavioural RAM and a transaction-level reference model.

module tb_mem_initiator;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 8;
    localparam int WR_CYCLES = 3;
    localparam int RD_WAIT   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [int];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    mem_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .WR_CYCLES(WR_CYCLES), .RD_WAIT(RD_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: write on rising mem_wr, asynchronous read.
    always @(posedge mem_wr) ram[mem_address] <= mem_din;
    assign mem_dout = ram[mem_address];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns just after the accept edge.
    task automatic start(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    // Follows a transaction from its accept edge to consumption and
    // compares against the transaction-level expectations.
    task automatic run_tail(input string tag, input logic we,
                            input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d,
                            input logic [DATA_W-1:0] exp, input int bp);
        int e = 0;
        int wr = 0;
        int first = -1;
        int unstable = 0;
        int bp_bad = 0;
        logic [DATA_W-1:0] held;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && e < 50) begin
            if (mem_wr) begin
                wr++;
                if (first < 0) first = e;
            end
            if (mem_address !== a) unstable++;
            if (we && mem_din !== d) unstable++;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(e), we ? 32'(WR_CYCLES + 2) : 32'(RD_WAIT));
        chk({tag, "_wr_cycles"}, 32'(wr), we ? 32'(WR_CYCLES) : 32'd0);
        chk({tag, "_wr_start"}, 32'(first), we ? 32'd1 : 32'hFFFF_FFFF);
        chk({tag, "_unstable"}, 32'(unstable), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp));
        held = rsp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== held || req_ready) bp_bad++;
        end
        if (bp > 0) chk({tag, "_bp_hold"}, 32'(bp_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        if (we) ref_mem[int'(a)] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] pool [16];
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              we;
        int                bad;
        int                e;

        vecs[0] = '{1'b1, 15'h1234, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 15'h1234, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 15'h0000, 8'h11, 8'h11};
        vecs[3] = '{1'b1, 15'h7FFF, 8'hEE, 8'hEE};
        vecs[4] = '{1'b0, 15'h0000, 8'h00, 8'h11};
        vecs[5] = '{1'b0, 15'h7FFF, 8'h00, 8'hEE};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_outs", {rsp_rdata, mem_din, 1'b0, mem_address}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            start(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            run_tail($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr,
                     vecs[i].wdata, vecs[i].exp, 0);
        end

        // Backpressure with a competing request at another address.
        start(1'b0, 15'h1234, 8'h00);
        @(negedge clk);
        req_addr = 15'h7FFF;
        e = 0;
        while (!rsp_valid && e < 20) begin
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        chk("bp_resp_seen", 32'(rsp_valid), 32'd1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (!rsp_valid || rsp_rdata !== 8'hA5) bad++;
            if (req_ready || mem_address !== 15'h1234) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_hold", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_no_early_accept", {16'd0, req_ready, mem_address}, {16'd0, 1'b1, 15'h1234});
        @(posedge clk);
        run_tail("bp_next", 1'b0, 15'h7FFF, 8'h00, 8'hEE, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 16; i++) pool[i] = ADDR_W'($urandom);
        for (int i = 0; i < 40; i++) begin
            a  = pool[$urandom_range(0, 15)];
            we = 1'($urandom_range(0, 1));
            if (!ref_mem.exists(int'(a))) we = 1'b1;
            d  = DATA_W'($urandom);
            start(we, a, d);
            run_tail($sformatf("rnd%0d", i), we, a, d,
                     we ? d : ref_mem[int'(a)], $urandom_range(0, 3));
        end

        // Asynchronous reset during the second mem_wr high cycle.
        start(1'b1, 15'h0100, 8'h5A);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wr_before_rst", 32'(mem_wr), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_wr_low", 32'(mem_wr), 32'd0);
        chk("rst_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
        chk("rst_mid_outs", {rsp_rdata, mem_din, 1'b0, mem_address}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || mem_wr) bad++;
            @(negedge clk);
        end
        chk("rst_no_resp", 32'(bad), 32'd0);
        start(1'b1, 15'h0100, 8'h3C);
        run_tail("after_rst_st", 1'b1, 15'h0100, 8'h3C, 8'h3C, 0);
        start(1'b0, 15'h0100, 8'h00);
        run_tail("after_rst_ld", 1'b0, 15'h0100, 8'h00, 8'h3C, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
